// File: rtl/powlib_busburst_pkg.sv
// Shared constants for the bus burst generator: FSM state encodings.
// Used by powlib_busburst and powlib_busburst_addrgen.
package powlib_busburst_pkg;

   localparam logic [0:0] POWLIB_BUSBURST_IDLE  = 1'b0;
   localparam logic [0:0] POWLIB_BUSBURST_BURST = 1'b1;

endpackage

// File: rtl/powlib_busburst_addrgen.sv
// Burst address/beat counter: latches a command, steps the address once per loaded beat.
// POWLIB_BUSBURST_WRAP_EN: wrap the address inside an aligned 2^B_WB-beat window.
module powlib_busburst_addrgen
   import powlib_busburst_pkg::*;
#(
   parameter int B_AW = 2,
   parameter int B_LW = 4,
   parameter int B_WB = 1
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [B_AW-1:0] cmdaddr,
   input  logic [B_LW-1:0] cmdlen,
   input  logic            step,
   output logic [B_AW-1:0] addr,
   output logic            zero
);

`ifdef POWLIB_BUSBURST_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif
   // Number of low address bits that increment; the rest hold.
   localparam int WIN = (WRAP && (B_WB < B_AW)) ? B_WB : B_AW;

   logic [B_AW-1:0] addr_reg;
   logic [B_AW-1:0] addr_next;
   logic [B_LW-1:0] cnt_reg;

   generate
      if (WIN < B_AW) begin : g_wrap
         logic [WIN-1:0] low_next;
         assign low_next  = addr_reg[WIN-1:0] + 1'b1;
         assign addr_next = {addr_reg[B_AW-1:WIN], low_next};
      end else begin : g_lin
         assign addr_next = addr_reg + 1'b1;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_reg <= '0;
         cnt_reg  <= '0;
      end else if (load) begin
         addr_reg <= cmdaddr;
         cnt_reg  <= cmdlen;
      end else if (step) begin
         addr_reg <= addr_next;
         cnt_reg  <= cnt_reg - 1'b1;
      end
   end

   assign addr = addr_reg;
   assign zero = (cnt_reg == '0);

endmodule

// File: rtl/powlib_busburst.sv
// Burst generator: pairs one (address, length) command with a data stream and emits
// address/data beats on a valid/ready bus, throttled by wrnf. Option: POWLIB_BUSBURST_WRAP_EN.
module powlib_busburst
   import powlib_busburst_pkg::*;
#(
   parameter int B_AW = 2,
   parameter int B_DW = 4,
   parameter int B_LW = 4,
   parameter int B_WB = 1
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic [B_AW-1:0] cmdaddr,
   input  logic [B_LW-1:0] cmdlen,
   input  logic            cmdvld,
   output logic            cmdrdy,
   input  logic [B_DW-1:0] din,
   input  logic            dinvld,
   output logic            dinrdy,
   output logic [B_DW-1:0] wrdata,
   output logic [B_AW-1:0] wraddr,
   output logic            wrvld,
   input  logic            wrrdy,
   input  logic            wrnf,
   output logic            busy,
   output logic            done
);

   logic [0:0]      state_reg;
   logic [0:0]      state_next;
   logic            in_burst;
   logic            slot_free;
   logic            accept;
   logic            ld;
   logic            zero;
   logic [B_AW-1:0] addr;
   logic            wrvld_reg;
   logic            last_reg;
   logic [B_DW-1:0] wrdata_reg;
   logic [B_AW-1:0] wraddr_reg;

   assign in_burst  = (state_reg == POWLIB_BUSBURST_BURST);
   assign slot_free = !wrvld_reg || wrrdy;
   // Gated by rst so the handshake outputs read 0 while reset is held.
   assign cmdrdy    = rst && (state_reg == POWLIB_BUSBURST_IDLE);
   assign accept    = cmdvld && cmdrdy;
   assign dinrdy    = in_burst && slot_free && !wrnf;
   assign ld        = dinrdy && dinvld;

   powlib_busburst_addrgen #(
      .B_AW (B_AW),
      .B_LW (B_LW),
      .B_WB (B_WB)
   ) u_addrgen (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .cmdaddr (cmdaddr),
      .cmdlen  (cmdlen),
      .step    (ld),
      .addr    (addr),
      .zero    (zero)
   );

   always_comb begin
      state_next = state_reg;
      if (state_reg == POWLIB_BUSBURST_IDLE) begin
         if (accept) state_next = POWLIB_BUSBURST_BURST;
      end else if (ld && zero) begin
         state_next = POWLIB_BUSBURST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= POWLIB_BUSBURST_IDLE;
      else      state_reg <= state_next;
   end

   // Output beat register: a presented beat holds until wrrdy, regardless of wrnf.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrvld_reg <= 1'b0;
         last_reg  <= 1'b0;
      end else if (ld) begin
         wrvld_reg <= 1'b1;
         last_reg  <= zero;
      end else if (wrrdy) begin
         wrvld_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (ld) begin
         wrdata_reg <= din;
         wraddr_reg <= addr;
      end
   end

   assign wrdata = wrdata_reg;
   assign wraddr = wraddr_reg;
   assign wrvld  = wrvld_reg;
   assign done   = wrvld_reg && wrrdy && last_reg;
   assign busy   = in_burst || wrvld_reg;

endmodule

// File: tb/tb_powlib_busburst.sv
// Bench for powlib_busburst: directed scenarios with literal expectations plus a
// randomized run checked against a transaction-level beat model (default build).
module tb_powlib_busburst;

   localparam int AW = 2;
   localparam int DW = 4;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] cmdaddr = '0;
   logic [LW-1:0] cmdlen = '0;
   logic          cmdvld = 1'b0;
   logic          cmdrdy;
   logic [DW-1:0] din = '0;
   logic          dinvld = 1'b0;
   logic          dinrdy;
   logic [DW-1:0] wrdata;
   logic [AW-1:0] wraddr;
   logic          wrvld;
   logic          wrrdy = 1'b0;
   logic          wrnf = 1'b0;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   powlib_busburst #(.B_AW(AW), .B_DW(DW), .B_LW(LW), .B_WB(1)) dut (
      .clk(clk), .rst(rst),
      .cmdaddr(cmdaddr), .cmdlen(cmdlen), .cmdvld(cmdvld), .cmdrdy(cmdrdy),
      .din(din), .dinvld(dinvld), .dinrdy(dinrdy),
      .wrdata(wrdata), .wraddr(wraddr), .wrvld(wrvld), .wrrdy(wrrdy), .wrnf(wrnf),
      .busy(busy), .done(done)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic [LW-1:0] l;
   } cmd_t;

   // Stimulus queues (what is still to be offered to the DUT).
   cmd_t          cmd_q[$];
   logic [DW-1:0] data_q[$];
   // Model: expected bus beats in order.
   logic [AW-1:0] exp_addr_q[$];
   logic [DW-1:0] exp_data_q[$];
   logic          exp_last_q[$];

   int   p_dinvld = 100;
   int   p_wrrdy  = 100;
   int   p_wrnf   = 0;
   logic cmd_hs = 1'b0;
   logic din_hs = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Each beat i of a burst goes to (a+i) mod 2^AW and carries the next stream word.
   task automatic push_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                             input bit rnd, input logic [DW-1:0] d0);
      cmd_t          c;
      logic [DW-1:0] d;
      c.a = a;
      c.l = l;
      cmd_q.push_back(c);
      for (int i = 0; i <= int'(l); i++) begin
         d = rnd ? DW'($urandom) : d0 + DW'(i);
         data_q.push_back(d);
         exp_data_q.push_back(d);
         exp_addr_q.push_back(AW'((int'(a) + i) % (1 << AW)));
         exp_last_q.push_back(i == int'(l));
      end
   endtask

   task automatic flush();
      cmd_q.delete();
      data_q.delete();
      exp_addr_q.delete();
      exp_data_q.delete();
      exp_last_q.delete();
      cmd_hs = 1'b0;
      din_hs = 1'b0;
      cmdvld = 1'b0;
      dinvld = 1'b0;
   endtask

   // Advance one clock: retire last cycle's handshakes, drive, then stop at the negedge.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (cmd_hs) void'(cmd_q.pop_front());
      if (din_hs) void'(data_q.pop_front());
      cmdvld = (cmd_q.size() != 0);
      if (cmdvld) begin
         cmdaddr = cmd_q[0].a;
         cmdlen  = cmd_q[0].l;
      end
      dinvld = (data_q.size() != 0) && ($urandom_range(99) < p_dinvld);
      din    = (data_q.size() != 0) ? data_q[0] : '0;
      wrrdy  = ($urandom_range(99) < p_wrrdy);
      wrnf   = ($urandom_range(99) < p_wrnf);
      @(negedge clk);
      cmd_hs = cmdvld && cmdrdy;
      din_hs = dinvld && dinrdy;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_addr_q.size() != 0 || busy) && n < 30000) begin
         cycle();
         n++;
      end
      check({name, "_beats_left"}, exp_addr_q.size(), 0);
      check({name, "_idle_busy"}, busy, 0);
   endtask

   // Compare process: every bus handshake must match the next modelled beat.
   logic          prev_hold = 1'b0;
   logic [AW-1:0] prev_addr;
   logic [DW-1:0] prev_data;
   logic [AW-1:0] ea;
   logic [DW-1:0] ed;
   logic          el;

   always @(negedge clk) begin
      if (!rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_vld", wrvld, 1);
            check("hold_addr", wraddr, prev_addr);
            check("hold_data", wrdata, prev_data);
         end
         check("wrnf_blocks_dinrdy", dinrdy && wrnf, 0);
         if (wrvld) check("busy_with_vld", busy, 1);
         if (wrvld && wrrdy) begin
            if (exp_addr_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat: got addr %0h data %0h expected no beat", wraddr, wrdata);
            end else begin
               ea = exp_addr_q.pop_front();
               ed = exp_data_q.pop_front();
               el = exp_last_q.pop_front();
               check("beat_addr", wraddr, ea);
               check("beat_data", wrdata, ed);
               check("beat_done", done, el);
            end
         end else begin
            check("done_without_hs", done, 0);
         end
         prev_hold = wrvld && !wrrdy;
         prev_addr = wraddr;
         prev_data = wrdata;
      end
   end

   initial begin
      // Power-on reset
      cycle(); cycle();
      check("rst_wrvld", wrvld, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cmdrdy", cmdrdy, 0);
      check("rst_dinrdy", dinrdy, 0);
      rst = 1'b1;
      #1;
      check("post_rst_cmdrdy", cmdrdy, 1);

      // Basic 4-beat burst, exact timing
      push_burst(2'd0, 4'd3, 0, 4'd1);
      cycle();
      check("t2_cmd_hs", cmd_hs, 1);
      check("t2_a_wrvld", wrvld, 0);
      cycle();
      check("t2_b_wrvld", wrvld, 0);
      check("t2_b_dinrdy", dinrdy, 1);
      check("t2_b_cmdrdy", cmdrdy, 0);
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("t2_wrvld", wrvld, 1);
         check("t2_addr", wraddr, k);
         check("t2_data", wrdata, k + 1);
         check("t2_done", done, k == 3);
      end
      cycle();
      check("t2_end_wrvld", wrvld, 0);
      check("t2_end_busy", busy, 0);
      drain("t2");

      // Address carry: 3 -> 0
      push_burst(2'd3, 4'd1, 0, 4'd5);
      cycle(); cycle(); cycle();
      check("t3_addr0", wraddr, 3);
      check("t3_data0", wrdata, 5);
      cycle();
      check("t3_addr1", wraddr, 0);
      check("t3_data1", wrdata, 6);
      check("t3_done", done, 1);
      drain("t3");

      // Backpressure on beat 1 for 3 cycles
      p_wrrdy = 0;
      push_burst(2'd1, 4'd3, 0, 4'd7);
      cycle(); cycle();
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("t4_hold_addr", wraddr, 1);
         check("t4_hold_data", wrdata, 7);
         check("t4_dinrdy", dinrdy, 0);
      end
      p_wrrdy = 100;
      drain("t4");

      // wrnf rising with a beat pending
      push_burst(2'd0, 4'd3, 0, 4'd2);
      cycle(); cycle();
      p_wrnf = 100;
      cycle();
      check("t5_pending_vld", wrvld, 1);
      check("t5_pending_addr", wraddr, 0);
      check("t5_nf_dinrdy", dinrdy, 0);
      cycle();
      check("t5_no_new_beat", wrvld, 0);
      cycle();
      check("t5_still_blocked", wrvld, 0);
      p_wrnf = 0;
      drain("t5a");

      // dinvld toggling inserts bubbles
      push_burst(2'd1, 4'd3, 0, 4'd9);
      for (int k = 0; k < 12; k++) begin
         p_dinvld = (k % 2 == 0) ? 100 : 0;
         cycle();
      end
      p_dinvld = 100;
      drain("t5b");

      // Second command accepted during the last-beat handshake
      push_burst(2'd0, 4'd1, 0, 4'd1);
      push_burst(2'd2, 4'd1, 0, 4'd3);
      cycle(); cycle(); cycle();
      check("t6_c_cmdrdy", cmdrdy, 0);
      cycle();
      check("t6_d_done", done, 1);
      check("t6_d_cmd_hs", cmd_hs, 1);
      cycle();
      check("t6_e_wrvld", wrvld, 0);
      cycle();
      check("t6_f_addr", wraddr, 2);
      check("t6_f_data", wrdata, 3);
      check("t6_f_done", done, 0);
      cycle();
      check("t6_g_addr", wraddr, 3);
      check("t6_g_done", done, 1);
      drain("t6");

      // Reset while beat 2 of 4 is pending
      push_burst(2'd0, 4'd3, 0, 4'd10);
      cycle(); cycle(); cycle(); cycle();
      check("t1_pending_addr", wraddr, 1);
      #2 rst = 1'b0;
      #1;
      check("t1_rst_wrvld", wrvld, 0);
      check("t1_rst_busy", busy, 0);
      check("t1_rst_done", done, 0);
      check("t1_rst_cmdrdy", cmdrdy, 0);
      flush();
      cycle();
      check("t1_in_rst_done", done, 0);
      cycle();
      rst = 1'b1;
      #1;
      check("t1_rel_cmdrdy", cmdrdy, 1);
      check("t1_rel_busy", busy, 0);
      check("t1_rel_wrvld", wrvld, 0);

      // Randomized bursts against the beat model
      for (int b = 0; b < 40; b++)
         push_burst(AW'($urandom), LW'($urandom), 1, '0);
      for (int n = 0; n < 30000 && exp_addr_q.size() != 0; n++) begin
         if (n % 16 == 0) begin
            p_dinvld = $urandom_range(30, 100);
            p_wrrdy  = $urandom_range(30, 100);
            p_wrnf   = $urandom_range(0, 40);
         end
         cycle();
      end
      p_wrnf = 0;
      p_wrrdy = 100;
      p_dinvld = 100;
      drain("rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
